ctrl_seq: RTL

//  Multi-cycle instruction sequencer that drives the 4-bit program counter (pc) of the microprocessor.

---
 rtl/ctrl_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle instruction sequencer for the 4-bit microprocessor.
//
// Runs one instruction at a time: FETCH latches the ROM word addressed by the
// external pc, DECODE screens for halt and illegal opcodes, EXEC issues ALU
// starts and resolves branches, WAIT covers the multi-cycle MUL, and ADVANCE
// releases the pc for exactly one edge. HALT is sticky until rst.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   run        in   1 = execute, 0 = stop at the next instruction boundary
//   instr      in   [7:4] opcode, [3:0] operand, from ROM at pc_out
//   alu_done   in   multi-cycle ALU completion, only looked at in WAIT
//   zero_flag  in   ALU zero flag of the last completed result
//   busy       out  1 = pc holds, 0 = pc advances (ADVANCE only)
//   jump_flag  out  pc loads jump_addr at this edge
//   jump_addr  out  branch target, IR[3:0]
//   alu_op     out  ALU function, IR[6:4] (000 for LDI)
//   alu_start  out  one-cycle ALU start pulse in EXEC
//   reg_we     out  one-cycle register-file write in ADVANCE
//   imm        out  LDI immediate, IR[3:0]
//   halted     out  sticky: HALT, illegal opcode or ALU timeout
//   fault      out  sticky: illegal opcode or ALU timeout
//   state_out  out  current FSM state for debug
module ctrl_seq #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] instr,
    input  logic       alu_done,
    input  logic       zero_flag,
    output logic       busy,
    output logic       jump_flag,
    output logic [3:0] jump_addr,
    output logic [2:0] alu_op,
    output logic       alu_start,
    output logic       reg_we,
    output logic [3:0] imm,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state_out
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StDecode  = 3'd2;
    localparam logic [2:0] StExec    = 3'd3;
    localparam logic [2:0] StWait    = 3'd4;
    localparam logic [2:0] StAdvance = 3'd5;
    localparam logic [2:0] StHalt    = 3'd6;

    localparam logic [3:0] OpLdi = 4'h1;
    localparam logic [3:0] OpMul = 4'h7;
    localparam logic [3:0] OpJmp = 4'h8;
    localparam logic [3:0] OpJz  = 4'h9;
    localparam logic [3:0] OpJnz = 4'hA;
    localparam logic [3:0] OpHlt = 4'hF;

    // At least one bit so MAX_WAIT = 1 still elaborates.
    localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

    logic [2:0]      state_q, state_d;
    logic [7:0]      ir_q, ir_d;
    logic            taken_q, taken_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            halted_q, halted_d;
    logic            fault_q, fault_d;

    logic [3:0] opcode;
    logic       in_advance;
    logic       op_alu;    // ADD..MUL: opcodes that start the ALU
    logic       op_write;  // LDI..MUL: opcodes that write the register file

    assign opcode   = ir_q[7:4];
    assign op_alu   = (opcode >= 4'h2) && (opcode <= OpMul);
    assign op_write = (opcode >= OpLdi) && (opcode <= OpMul);

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        taken_d  = taken_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                ir_d    = instr;
                state_d = StDecode;
            end
            StDecode: begin
                if (opcode == OpHlt) begin
                    halted_d = 1'b1;
                    state_d  = StHalt;
                end else if (opcode > OpJnz) begin
                    // B..E are unassigned.
                    halted_d = 1'b1;
                    fault_d  = 1'b1;
                    state_d  = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                taken_d = (opcode == OpJmp) ||
                          ((opcode == OpJz) && zero_flag) ||
                          ((opcode == OpJnz) && !zero_flag);
                if (opcode == OpMul) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    state_d = StAdvance;
                end
            end
            StWait: begin
                if (alu_done) begin
                    state_d = StAdvance;
                end else if (cnt_q == CntLast) begin
                    halted_d = 1'b1;
                    fault_d  = 1'b1;
                    state_d  = StHalt;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAdvance: begin
                // run is only sampled here, so a drop never aborts an instruction.
                state_d = run ? StFetch : StIdle;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ir_q     <= '0;
            taken_q  <= 1'b0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            taken_q  <= taken_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    // Strobes decode straight from state and IR, so reset clears them at once.
    assign in_advance = (state_q == StAdvance);
    assign busy       = !in_advance;
    assign jump_flag  = in_advance && taken_q;
    assign jump_addr  = ir_q[3:0];
    assign alu_op     = (opcode == OpLdi) ? 3'b000 : ir_q[6:4];
    assign alu_start  = (state_q == StExec) && op_alu;
    assign reg_we     = in_advance && op_write;
    assign imm        = ir_q[3:0];
    assign halted     = halted_q;
    assign fault      = fault_q;
    assign state_out  = state_q;

endmodule
